// File: rtl/iob_cache_axi_read_arbiter_pkg.sv
// Shared AXI read-arbiter definitions: fixed AR attributes, FSM encoding and
// the round-robin pointer advance rule.
package iob_cache_axi_read_arbiter_pkg;

  localparam logic [3:0] AXI_ARCACHE    = 4'b0011;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  // Pointer moves to the master just after the one that finished, wrapping to 0.
  function automatic int rr_next(input int grant, input int n);
    return (grant == n - 1) ? 0 : grant + 1;
  endfunction

endpackage

// File: rtl/iob_cache_rr_prio_enc.sv
// Cyclic priority encoder: picks the first asserted request at or after ptr,
// wrapping around. Purely combinational.
module iob_cache_rr_prio_enc #(
  parameter int N     = 2,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             valid,
  output logic [SEL_W-1:0] idx
);

  localparam int OFF_W = SEL_W + 1;

  // Cyclic distance of each index from ptr; the smallest requesting distance wins.
  logic [OFF_W-1:0] offs [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_off
      assign offs[gi] = (ptr <= SEL_W'(gi)) ? (OFF_W'(gi) - OFF_W'(ptr))
                                            : (OFF_W'(gi + N) - OFF_W'(ptr));
    end
  endgenerate

  logic [OFF_W-1:0] best;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    best  = OFF_W'(N);
    for (int k = 0; k < N; k++) begin
      if (req[k] && (offs[k] < best)) begin
        best  = offs[k];
        idx   = SEL_W'(k);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iob_cache_axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI4 read channel between several cache
// back ends; one outstanding burst, grant held from AR accept to last R beat.
module iob_cache_axi_read_arbiter
  import iob_cache_axi_read_arbiter_pkg::*;
#(
  parameter int N_MASTERS  = 2,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_ID_W   = 1,
  parameter int AXI_LEN_W  = 8
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [N_MASTERS-1:0]            m_arvalid_i,
  output logic [N_MASTERS-1:0]            m_arready_o,
  input  logic [N_MASTERS*AXI_ADDR_W-1:0] m_araddr_i,
  input  logic [N_MASTERS*AXI_ID_W-1:0]   m_arid_i,
  input  logic [N_MASTERS*AXI_LEN_W-1:0]  m_arlen_i,
  input  logic [N_MASTERS*3-1:0]          m_arsize_i,
  input  logic [N_MASTERS*2-1:0]          m_arburst_i,
  output logic [N_MASTERS-1:0]            m_rvalid_o,
  input  logic [N_MASTERS-1:0]            m_rready_i,
  output logic [AXI_DATA_W-1:0]           m_rdata_o,
  output logic [1:0]                      m_rresp_o,
  output logic                            m_rlast_o,
  output logic [AXI_ID_W-1:0]             m_rid_o,
  output logic [AXI_ADDR_W-1:0]           axi_araddr_o,
  output logic [AXI_ID_W-1:0]             axi_arid_o,
  output logic [AXI_LEN_W-1:0]            axi_arlen_o,
  output logic [2:0]                      axi_arsize_o,
  output logic [1:0]                      axi_arburst_o,
  output logic                            axi_arvalid_o,
  output logic [2:0]                      axi_arprot_o,
  output logic                            axi_arlock_o,
  output logic [3:0]                      axi_arcache_o,
  output logic [3:0]                      axi_arqos_o,
  input  logic                            axi_arready_i,
  input  logic                            axi_rvalid_i,
  input  logic [AXI_DATA_W-1:0]           axi_rdata_i,
  input  logic [1:0]                      axi_rresp_i,
  input  logic                            axi_rlast_i,
  input  logic [AXI_ID_W-1:0]             axi_rid_i,
  output logic                            axi_rready_o,
  output logic                            busy_o
);

  localparam int SEL_W = $clog2(N_MASTERS);

  arb_state_t       state_reg;
  logic [SEL_W-1:0] grant_reg;
  logic [SEL_W-1:0] rr_ptr_reg;
  logic             enc_valid;
  logic [SEL_W-1:0] enc_idx;

  iob_cache_rr_prio_enc #(
    .N     (N_MASTERS),
    .SEL_W (SEL_W)
  ) u_prio_enc (
    .req   (m_arvalid_i),
    .ptr   (rr_ptr_reg),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  logic [AXI_ADDR_W-1:0] araddr_arr  [N_MASTERS];
  logic [AXI_ID_W-1:0]   arid_arr    [N_MASTERS];
  logic [AXI_LEN_W-1:0]  arlen_arr   [N_MASTERS];
  logic [2:0]            arsize_arr  [N_MASTERS];
  logic [1:0]            arburst_arr [N_MASTERS];

  logic is_addr;
  logic is_data;
  logic r_last_hs;

  assign is_addr = (state_reg == ADDR);
  assign is_data = (state_reg == DATA);

  genvar gi;
  generate
    for (gi = 0; gi < N_MASTERS; gi++) begin : g_master
      assign araddr_arr[gi]  = m_araddr_i[gi*AXI_ADDR_W +: AXI_ADDR_W];
      assign arid_arr[gi]    = m_arid_i[gi*AXI_ID_W +: AXI_ID_W];
      assign arlen_arr[gi]   = m_arlen_i[gi*AXI_LEN_W +: AXI_LEN_W];
      assign arsize_arr[gi]  = m_arsize_i[gi*3 +: 3];
      assign arburst_arr[gi] = m_arburst_i[gi*2 +: 2];
      assign m_arready_o[gi] = is_addr && (grant_reg == SEL_W'(gi)) && axi_arready_i;
      assign m_rvalid_o[gi]  = is_data && (grant_reg == SEL_W'(gi)) && axi_rvalid_i;
    end
  endgenerate

  // AR fields follow the grant only; validity is qualified separately by state.
  assign axi_araddr_o  = araddr_arr[grant_reg];
  assign axi_arid_o    = arid_arr[grant_reg];
  assign axi_arlen_o   = arlen_arr[grant_reg];
  assign axi_arsize_o  = arsize_arr[grant_reg];
  assign axi_arburst_o = arburst_arr[grant_reg];
  assign axi_arvalid_o = is_addr && m_arvalid_i[grant_reg];
  assign axi_arprot_o  = 3'b000;
  assign axi_arlock_o  = 1'b0;
  assign axi_arcache_o = AXI_ARCACHE;
  assign axi_arqos_o   = 4'b0000;

  assign axi_rready_o = is_data && m_rready_i[grant_reg];
  assign m_rdata_o    = axi_rdata_i;
  assign m_rresp_o    = axi_rresp_i;
  assign m_rlast_o    = axi_rlast_i;
  assign m_rid_o      = axi_rid_i;
  assign busy_o       = (state_reg != IDLE);

  assign r_last_hs = is_data && axi_rvalid_i && m_rready_i[grant_reg] && axi_rlast_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg  <= IDLE;
      grant_reg  <= '0;
      rr_ptr_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (enc_valid) begin
            grant_reg <= enc_idx;
            state_reg <= ADDR;
          end
        end
        ADDR: begin
          // A withdrawn request forfeits the slot without moving the pointer.
          if (!m_arvalid_i[grant_reg]) begin
            state_reg <= IDLE;
          end else if (axi_arready_i) begin
            state_reg <= DATA;
          end
        end
        DATA: begin
          if (r_last_hs) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= SEL_W'(rr_next(int'(grant_reg), N_MASTERS));
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
